// File: rtl/div_unit_dual.sv
// div_unit_dual
// Two identical iterative radix-4 integer dividers that sit in the exe stage
// beside the mul unit. The scoreboard steers each divide to one unit with
// req_unit_i. The result comes back after a fixed latency that does not
// depend on the data: 32 iteration edges for 64-bit ops and 16 for word ops.
// This latency matches the scoreboard's div shift chain.
//
// Ports
//   clk_i, rstn_i       clock; asynchronous active-low reset
//   flush_i             synchronous kill of both units (drops a coincident request)
//   req_valid_i         one-cycle divide command (no ready: see handshake note)
//   req_unit_i          target unit 0/1
//   req_word_i          1 = 32-bit (W) op, 0 = 64-bit op
//   req_signed_i        1 = signed, 0 = unsigned
//   req_rem_i           1 = remainder, 0 = quotient
//   dividend_i, divisor_i, tag_i   operands and destination tag
//   result_valid_o      one-cycle strobe while a unit is in DONE
//   result_o, result_tag_o         result and its tag (0 when no strobe)
//   busy_o              per-unit occupied flags (ITER or DONE)
//   req_err_o           pulse, one cycle after a request hit a unit in ITER
//   wb_conflict_o       pulse when both units are in DONE together (unit 0 wins)
//
// Handshake: req_valid_i is a fire-and-forget command with no ready. A unit
// accepts it when it is IDLE, or in DONE (back-to-back). If the unit is in
// ITER, the request is dropped and req_err_o reports the drop. Results also
// have no backpressure; the scoreboard reserves the writeback slot.
//
// Each unit's FSM state is held in g_unit[u].state_q, so it can be probed
// from outside the module.
// Only XLEN = 64 is supported; the word-op slices assume it.

module div_unit_dual #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 6
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  input  logic             req_unit_i,
  input  logic             req_word_i,
  input  logic             req_signed_i,
  input  logic             req_rem_i,
  input  logic [XLEN-1:0]  dividend_i,
  input  logic [XLEN-1:0]  divisor_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             result_valid_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] result_tag_o,
  output logic [1:0]       busy_o,
  output logic             req_err_o,
  output logic             wb_conflict_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  // One restoring radix-2 step. The partial remainder r is always below the
  // divisor, so after the shift it fits in XLEN+1 bits. Bit XLEN of the
  // trial difference is the borrow, i.e. the inverse of the quotient bit.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] r,
                                                 input logic [XLEN-1:0] d,
                                                 input logic [XLEN-1:0] s);
    logic [XLEN:0] r_sh;
    logic [XLEN:0] r_sub;
    logic          q_bit;
    r_sh  = {r, d[XLEN-1]};
    r_sub = r_sh - {1'b0, s};
    q_bit = ~r_sub[XLEN];
    return {(q_bit ? r_sub[XLEN-1:0] : r_sh[XLEN-1:0]), d[XLEN-2:0], q_bit};
  endfunction

  // ------------------------------------------------------------------
  // Request decode, shared by both units
  // ------------------------------------------------------------------
  logic            a_neg, b_neg, req_dz, req_ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, dvd_init;

  always_comb begin
    if (req_word_i) begin
      a_ext = req_signed_i ? {{32{dividend_i[31]}}, dividend_i[31:0]} : {32'b0, dividend_i[31:0]};
      b_ext = req_signed_i ? {{32{divisor_i[31]}}, divisor_i[31:0]}   : {32'b0, divisor_i[31:0]};
    end else begin
      a_ext = dividend_i;
      b_ext = divisor_i;
    end
    a_neg   = req_signed_i & a_ext[XLEN-1];
    b_neg   = req_signed_i & b_ext[XLEN-1];
    a_abs   = a_neg ? -a_ext : a_ext;
    b_abs   = b_neg ? -b_ext : b_ext;
    req_dz  = (b_ext == '0);
    req_ovf = req_signed_i & (a_ext == (req_word_i ? MIN_W : MIN_D)) & (b_ext == '1);
    // A word magnitude is at most 2^31, so it fits in 32 bits. It is
    // parked in the top half, so 32 shifts leave the quotient in [31:0].
    dvd_init = req_word_i ? {a_abs[31:0], 32'b0} : a_abs;
  end

  // ------------------------------------------------------------------
  // Divider units
  // ------------------------------------------------------------------
  logic [1:0]       done, busy, err_hit;
  logic [XLEN-1:0]  unit_res [2];
  logic [TAG_W-1:0] unit_tag [2];

  for (genvar u = 0; u < 2; u++) begin : g_unit
    state_e           state_q, state_d;
    logic [4:0]       cnt_q;
    logic [XLEN-1:0]  rem_q, dvd_q, dvs_q;
    logic             word_q, rem_op_q, qneg_q, rneg_q, dz_q, ovf_q;
    logic [TAG_W-1:0] tag_q;
    logic             hit, accept;
    logic [XLEN-1:0]  r1, d1, r2, d2;
    logic [XLEN-1:0]  q_raw, q_fix, r_fix, res;

    assign hit    = req_valid_i & ~flush_i & (req_unit_i == 1'(u));
    assign accept = hit & (state_q != S_ITER);

    always_comb begin
      {r1, d1} = div_step(rem_q, dvd_q, dvs_q);
      {r2, d2} = div_step(r1, d1, dvs_q);
    end

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        S_IDLE:  if (accept) state_d = S_ITER;
        S_ITER:  if (cnt_q == 5'd0) state_d = S_DONE;
        S_DONE:  state_d = accept ? S_ITER : S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        rem_q    <= '0;
        dvd_q    <= '0;
        dvs_q    <= '0;
        word_q   <= 1'b0;
        rem_op_q <= 1'b0;
        qneg_q   <= 1'b0;
        rneg_q   <= 1'b0;
        dz_q     <= 1'b0;
        ovf_q    <= 1'b0;
        tag_q    <= '0;
      end else begin
        state_q <= state_d;
        if (accept) begin
          cnt_q    <= req_word_i ? 5'd15 : 5'd31;
          rem_q    <= '0;
          dvd_q    <= dvd_init;
          dvs_q    <= b_abs;
          word_q   <= req_word_i;
          rem_op_q <= req_rem_i;
          qneg_q   <= a_neg ^ b_neg;
          rneg_q   <= a_neg;
          dz_q     <= req_dz;
          ovf_q    <= req_ovf;
          tag_q    <= tag_i;
        end else if (state_q == S_ITER) begin
          rem_q <= r2;
          dvd_q <= d2;
          cnt_q <= cnt_q - 5'd1;
        end
      end
    end

    // Result formatting. With a zero divisor, every trial subtract succeeds.
    // The remainder register therefore collects |dividend| unchanged, and the
    // sign fix turns it back into the dividend. Only the quotient needs an
    // override in that case.
    always_comb begin
      q_raw = word_q ? {32'b0, dvd_q[31:0]} : dvd_q;
      q_fix = qneg_q ? -q_raw : q_raw;
      r_fix = rneg_q ? -rem_q : rem_q;
      res   = rem_op_q ? r_fix : q_fix;
      if (dz_q && !rem_op_q) res = '1;
      if (ovf_q) res = rem_op_q ? '0 : (word_q ? MIN_W : MIN_D);
      if (word_q) res = {{32{res[31]}}, res[31:0]};
    end

    assign done[u]     = (state_q == S_DONE);
    assign busy[u]     = (state_q != S_IDLE);
    assign err_hit[u]  = hit & (state_q == S_ITER);
    assign unit_res[u] = res;
    assign unit_tag[u] = tag_q;
  end

  // ------------------------------------------------------------------
  // Writeback mux and status
  // ------------------------------------------------------------------
  logic req_err_q;

  always_comb begin
    result_valid_o = |done;
    wb_conflict_o  = &done;
    result_o       = '0;
    result_tag_o   = '0;
    if (done[0]) begin
      result_o     = unit_res[0];
      result_tag_o = unit_tag[0];
    end else if (done[1]) begin
      result_o     = unit_res[1];
      result_tag_o = unit_tag[1];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) req_err_q <= 1'b0;
    else         req_err_q <= |err_hit;
  end

  assign busy_o    = busy;
  assign req_err_o = req_err_q;

endmodule

// File: tb/tb_div_unit_dual.sv
// Directed bench for div_unit_dual. Inputs are driven and outputs are
// sampled on the falling edge. "n" counts the rising edges after the edge
// that accepts a request (E0), so the DONE cycle of a 64-bit op is seen at
// n = 32.
module tb_div_unit_dual;

  logic        clk, rstn, flush;
  logic        req_valid, req_unit, req_word, req_signed, req_rem;
  logic [63:0] dividend, divisor;
  logic [5:0]  tag;
  logic        result_valid_o;
  logic [63:0] result_o;
  logic [5:0]  result_tag_o;
  logic [1:0]  busy_o;
  logic        req_err_o, wb_conflict_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [5:0]  exp_tag_q[$];

  div_unit_dual #(.XLEN(64), .TAG_W(6)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_unit_i     (req_unit),
    .req_word_i     (req_word),
    .req_signed_i   (req_signed),
    .req_rem_i      (req_rem),
    .dividend_i     (dividend),
    .divisor_i      (divisor),
    .tag_i          (tag),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .result_tag_o   (result_tag_o),
    .busy_o         (busy_o),
    .req_err_o      (req_err_o),
    .wb_conflict_o  (wb_conflict_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tg, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_req(input logic unit, input logic word, input logic sgn, input logic rem,
                           input logic [63:0] a, input logic [63:0] b, input logic [5:0] tg);
    req_valid  = 1'b1;
    req_unit   = unit;
    req_word   = word;
    req_signed = sgn;
    req_rem    = rem;
    dividend   = a;
    divisor    = b;
    tag        = tg;
  endtask

  task automatic idle_req();
    req_valid  = 1'b0;
    req_unit   = 1'b0;
    req_word   = 1'b0;
    req_signed = 1'b0;
    req_rem    = 1'b0;
    dividend   = '0;
    divisor    = '0;
    tag        = '0;
  endtask

  // scoreboard: compare the current strobe against the next expected entry
  task automatic sb_pop(input string tg);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_extra: unexpected result 0x%0h tag %0d", tg, result_o, result_tag_o);
    end else begin
      check_eq({tg, "_res"}, result_o, exp_q.pop_front());
      check_eq({tg, "_tag"}, 64'(result_tag_o), 64'(exp_tag_q.pop_front()));
    end
  endtask

  // Runs one isolated op: checks latency, a single strobe, data, tag, idle after.
  task automatic run_single(input string nm, input logic unit, input logic word, input logic sgn,
                            input logic rem, input logic [63:0] a, input logic [63:0] b,
                            input logic [5:0] tg, input logic [63:0] exp);
    int          lat, first, strobes;
    logic [63:0] res;
    logic [5:0]  rtag;
    lat = word ? 16 : 32;
    first = 0;
    strobes = 0;
    res = '0;
    rtag = '0;
    drive_req(unit, word, sgn, rem, a, b, tg);
    @(negedge clk);
    idle_req();
    for (int n = 1; n <= lat + 2; n++) begin
      @(negedge clk);
      if (result_valid_o) begin
        strobes++;
        if (first == 0) begin
          first = n;
          res   = result_o;
          rtag  = result_tag_o;
        end
      end
    end
    check_eq({nm, "_lat"}, 64'(first), 64'(lat));
    check_eq({nm, "_strobes"}, 64'(strobes), 64'd1);
    check_eq({nm, "_res"}, res, exp);
    check_eq({nm, "_tag"}, 64'(rtag), 64'(tg));
    check_eq({nm, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int u0_at, u1_at, conflicts, strobes, errs, first;
    int at_q[$];
    logic [63:0] res;
    logic [5:0]  rtag;

    rstn  = 1'b0;
    flush = 1'b0;
    idle_req();
    repeat (3) @(negedge clk);
    check_eq("rst_busy",     64'(busy_o),         64'd0);
    check_eq("rst_valid",    64'(result_valid_o), 64'd0);
    check_eq("rst_result",   result_o,            64'd0);
    check_eq("rst_tag",      64'(result_tag_o),   64'd0);
    check_eq("rst_err",      64'(req_err_o),      64'd0);
    check_eq("rst_conflict", 64'(wb_conflict_o),  64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // directed single ops: name, unit, word, signed, rem, a, b, tag, expected
    run_single("divu",       1'b0, 1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 6'd5, 64'd14);
    run_single("remu",       1'b0, 1'b0, 1'b0, 1'b1, 64'd100, 64'd7, 6'd5, 64'd2);
    run_single("divw",       1'b1, 1'b1, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFEC, 64'd3, 6'd6, 64'hFFFFFFFFFFFFFFFA);
    run_single("remw",       1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFEC, 64'd3, 6'd7, 64'hFFFFFFFFFFFFFFFE);
    run_single("div_neg",    1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFF9C, 64'd7, 6'd12, 64'hFFFFFFFFFFFFFFF2);
    run_single("rem_neg",    1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFF9C, 64'd7, 6'd13, 64'hFFFFFFFFFFFFFFFE);
    run_single("divu_big",   1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h10, 6'd14, 64'h0FFFFFFFFFFFFFFF);
    run_single("remu_big",   1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h10, 6'd15, 64'hF);
    run_single("div_zero",   1'b0, 1'b0, 1'b1, 1'b0, 64'd5, 64'd0, 6'd20, 64'hFFFFFFFFFFFFFFFF);
    run_single("remu_zero",  1'b1, 1'b0, 1'b0, 1'b1, 64'h1234, 64'd0, 6'd21, 64'h1234);
    run_single("div_ovf",    1'b0, 1'b0, 1'b1, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 6'd22, 64'h8000000000000000);
    run_single("rem_ovf",    1'b1, 1'b0, 1'b1, 1'b1, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 6'd23, 64'd0);
    run_single("divw_ovf",   1'b0, 1'b1, 1'b1, 1'b0, 64'h80000000, 64'hFFFFFFFFFFFFFFFF, 6'd24, 64'hFFFFFFFF80000000);
    run_single("divuw_sext", 1'b1, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFF, 64'd1, 6'd25, 64'hFFFFFFFFFFFFFFFF);
    run_single("divw_negd",  1'b0, 1'b1, 1'b1, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 6'd26, 64'hFFFFFFFFFFFFFFFE);
    run_single("remuw_hi",   1'b1, 1'b1, 1'b0, 1'b1, 64'h0000000100000005, 64'd3, 6'd27, 64'd2);

    // dual unit: 64-bit to unit 0 at E0, word op to unit 1 at E1,
    // rejected request to busy unit 0 at E5
    exp_q.push_back(64'd10);  exp_tag_q.push_back(6'd2);
    exp_q.push_back(64'd100); exp_tag_q.push_back(6'd1);
    u0_at = 0; u1_at = 0; conflicts = 0;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 64'd1000, 64'd10, 6'd1);
    @(negedge clk);
    drive_req(1'b1, 1'b1, 1'b0, 1'b0, 64'd50, 64'd5, 6'd2);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (result_valid_o) begin
        if (result_tag_o == 6'd2) u1_at = n;
        if (result_tag_o == 6'd1) u0_at = n;
        sb_pop("dual");
      end
      if (wb_conflict_o) conflicts++;
      if (n == 5)  check_eq("dual_err_pulse", 64'(req_err_o), 64'd1);
      if (n == 6)  check_eq("dual_err_clear", 64'(req_err_o), 64'd0);
      if (n == 10) check_eq("dual_busy", 64'(busy_o), 64'd3);
      if (n == 4) drive_req(1'b0, 1'b0, 1'b0, 1'b0, 64'd999, 64'd3, 6'd9);
      else        idle_req();
    end
    check_eq("dual_u1_at",     64'(u1_at), 64'd17);
    check_eq("dual_u0_at",     64'(u0_at), 64'd32);
    check_eq("dual_conflicts", 64'(conflicts), 64'd0);
    check_eq("dual_sb_empty",  64'(exp_q.size()), 64'd0);
    check_eq("dual_idle",      64'(busy_o), 64'd0);

    // both units finish together: unit 0 wins, conflict pulses
    strobes = 0;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 64'd60, 64'd6, 6'd30);
    @(negedge clk);
    idle_req();
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      if (result_valid_o) strobes++;
      if (n == 32) begin
        check_eq("conf_pulse", 64'(wb_conflict_o), 64'd1);
        check_eq("conf_res",   result_o, 64'd10);
        check_eq("conf_tag",   64'(result_tag_o), 64'd30);
      end
      if (n == 15) drive_req(1'b1, 1'b1, 1'b0, 1'b0, 64'd8, 64'd2, 6'd31);
      else         idle_req();
    end
    check_eq("conf_strobes", 64'(strobes), 64'd1);
    check_eq("conf_idle",    64'(busy_o), 64'd0);

    // back-to-back on unit 0: second request at the DONE cycle's edge (E17)
    exp_q.push_back(64'd3); exp_tag_q.push_back(6'd10);
    exp_q.push_back(64'd5); exp_tag_q.push_back(6'd11);
    errs = 0;
    at_q.delete();
    drive_req(1'b0, 1'b1, 1'b0, 1'b0, 64'd9, 64'd3, 6'd10);
    @(negedge clk);
    idle_req();
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      if (result_valid_o) begin
        at_q.push_back(n);
        sb_pop("b2b");
      end
      if (req_err_o) errs++;
      if (n == 16) drive_req(1'b0, 1'b1, 1'b0, 1'b0, 64'd20, 64'd4, 6'd11);
      else         idle_req();
    end
    check_eq("b2b_strobes", 64'(at_q.size()), 64'd2);
    if (at_q.size() == 2) begin
      check_eq("b2b_first_at",  64'(at_q[0]), 64'd16);
      check_eq("b2b_second_at", 64'(at_q[1]), 64'd33);
    end
    check_eq("b2b_errs",     64'(errs), 64'd0);
    check_eq("b2b_sb_empty", 64'(exp_q.size()), 64'd0);

    // flush at E10 of a 64-bit op, new request at E11
    strobes = 0; first = 0; res = '0; rtag = '0;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 64'd1000, 64'd10, 6'd4);
    @(negedge clk);
    idle_req();
    for (int n = 1; n <= 46; n++) begin
      @(negedge clk);
      if (result_valid_o) begin
        strobes++;
        if (first == 0) begin
          first = n;
          res   = result_o;
          rtag  = result_tag_o;
        end
      end
      if (n == 10) check_eq("flush_busy", 64'(busy_o), 64'd0);
      flush = (n == 9);
      if (n == 10) drive_req(1'b0, 1'b0, 1'b0, 1'b0, 64'd77, 64'd7, 6'd3);
      else         idle_req();
    end
    check_eq("flush_at",      64'(first), 64'd43);
    check_eq("flush_strobes", 64'(strobes), 64'd1);
    check_eq("flush_res",     res, 64'd11);
    check_eq("flush_tag",     64'(rtag), 64'd3);

    // asynchronous reset during a DONE cycle
    drive_req(1'b1, 1'b1, 1'b0, 1'b0, 64'd21, 64'd7, 6'd7);
    @(negedge clk);
    idle_req();
    repeat (16) @(negedge clk);
    check_eq("arst_pre_valid", 64'(result_valid_o), 64'd1);
    check_eq("arst_pre_res",   result_o, 64'd3);
    #2 rstn = 1'b0;
    #1;
    check_eq("arst_valid", 64'(result_valid_o), 64'd0);
    check_eq("arst_res",   result_o, 64'd0);
    check_eq("arst_tag",   64'(result_tag_o), 64'd0);
    check_eq("arst_busy",  64'(busy_o), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
